nios2_dbg_cmd_sync: RTL

- Parametrised successor to the debug-slave sysclk side.
- Samples the JTAG-domain scan register and instruction register on each update-DR strobe, synchronises the strobes into clk, and buffers commands in a show-ahead FIFO with a valid/ready handshake toward the OCI.
- Decodes per-IR take_action / take_no_action pulses for any IR width.
- Sits between the virtual-JTAG TCK logic and the CPU debug module (ocimem, break, tracectrl).

---
 rtl/nios2_dbg_pkg.sv | 15 +
 rtl/nios2_dbg_pulse_sync.sv | 40 ++++
 rtl/nios2_dbg_cmd_sync.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared widths and the command entry layout for the debug command synchroniser.
package nios2_dbg_pkg;

  localparam int SR_WIDTH_D = 38;
  localparam int IR_WIDTH_D = 2;
  localparam int ACT_BIT_D  = 35;
  localparam int TSTAMP_W   = 16;

  typedef struct packed {
    logic [IR_WIDTH_D-1:0] ir;
    logic [SR_WIDTH_D-1:0] data;
    logic [TSTAMP_W-1:0]   ts;
  } cmd_entry_t;

endpackage

// File: rtl/nios2_dbg_pulse_sync.sv
// Brings a TCK-domain strobe level into clk and emits a registered one-cycle pulse per rise.
module nios2_dbg_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] arm_q;
  logic                   prev_q, prev_d;
  logic                   pulse_q;
  logic                   rise;

  // Until the chain has refilled after reset, prev holds its reset value of 1,
  // so a strobe already high at release never looks like a 0->1 edge.
  always_comb begin
    prev_d = arm_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      arm_q   <= '0;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], level_i};
      arm_q   <= {arm_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= prev_d;
      pulse_q <= rise;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/nios2_dbg_cmd_sync.sv
// Debug-slave sysclk side: strobe sync, show-ahead command FIFO, per-IR action decode.
// Optional entry timestamps are enabled by defining NIOS2_DBG_CMD_TSTAMP_EN.
module nios2_dbg_cmd_sync
  import nios2_dbg_pkg::*;
#(
  parameter int SR_WIDTH    = SR_WIDTH_D,
  parameter int IR_WIDTH    = IR_WIDTH_D,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = ACT_BIT_D,
  localparam int NUM_IR     = 2**IR_WIDTH,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SR_WIDTH-1:0] sr_in,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic                vs_udr,
  input  logic                vs_uir,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [SR_WIDTH-1:0] cmd_data,
  output logic [NUM_IR-1:0]   take_action,
  output logic [NUM_IR-1:0]   take_no_action,
  output logic                ir_update,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                overflow,
  input  logic                overflow_clr,
  output logic [TSTAMP_W-1:0] cmd_timestamp
);

  logic [1:0] rst_sync_q;
  logic       rst_int;

  // Asserts immediately, releases on a clk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  logic push, pop, full, wr_en, drop;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q;
  logic [IR_WIDTH-1:0] ir_mem   [FIFO_DEPTH];
  logic [SR_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [IR_WIDTH-1:0] last_ir_q;
  logic [SR_WIDTH-1:0] last_data_q;

  nios2_dbg_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(rst_int), .level_i(vs_udr), .pulse_o(push)
  );

  nios2_dbg_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(rst_int), .level_i(vs_uir), .pulse_o(ir_update)
  );

  assign cmd_valid = (level_q != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    if (wr_en & ~pop)      level_d = level_q + LVL_W'(1);
    else if (~wr_en & pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      last_ir_q   <= '0;
      last_data_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        last_ir_q   <= ir_mem[rd_ptr_q];
        last_data_q <= data_mem[rd_ptr_q];
      end
      level_q    <= level_d;
      overflow_q <= drop | (overflow_q & ~overflow_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ir_mem[wr_ptr_q]   <= ir_in;
      data_mem[wr_ptr_q] <= sr_in;
    end
  end

  // When empty the outputs keep showing the most recently popped entry.
  assign cmd_ir     = cmd_valid ? ir_mem[rd_ptr_q]   : last_ir_q;
  assign cmd_data   = cmd_valid ? data_mem[rd_ptr_q] : last_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      take_action[cmd_ir]    = cmd_data[ACT_BIT];
      take_no_action[cmd_ir] = ~cmd_data[ACT_BIT];
    end
  end

`ifdef NIOS2_DBG_CMD_TSTAMP_EN
  logic [TSTAMP_W-1:0] ts_cnt_q, last_ts_q;
  logic [TSTAMP_W-1:0] ts_mem [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      ts_cnt_q  <= '0;
      last_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TSTAMP_W'(1);
      if (pop) last_ts_q <= ts_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_cnt_q;
  end

  assign cmd_timestamp = cmd_valid ? ts_mem[rd_ptr_q] : last_ts_q;
`else
  assign cmd_timestamp = '0;
`endif

endmodule
